// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with push/pop strobes, occupancy status and error pulses.
// Optional almost_full/almost_empty outputs are enabled by defining SYNC_FIFO_ALMOST_EN.
module sync_fifo_param #(
    parameter  int DATA_W   = 8,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    parameter  int AE_LEVEL = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH
        || AF_LEVEL < 0 || AE_LEVEL < 0) begin : g_bad_param
        $error("sync_fifo_param: DEPTH must be a power of 2 >= 2, levels within 0..DEPTH");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_pop_ok;
    logic              w_push_ok;
    logic [ADDR_W:0]   w_wr_nxt;
    logic [ADDR_W:0]   w_rd_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_full_nxt;
    logic              w_empty_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    always_comb begin
        w_pop_ok    = pop & ~r_empty;
        w_push_ok   = push & (~r_full | w_pop_ok);
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        if (w_push_ok) w_wr_nxt = r_wr_ptr + PTR_ONE;
        if (w_pop_ok)  w_rd_nxt = r_rd_ptr + PTR_ONE;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + PTR_ONE;
            2'b01:   w_count_nxt = r_count - PTR_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_empty_nxt = (w_wr_nxt == w_rd_nxt);
        w_full_nxt  = (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0])
                    & (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]);
    end

    // Storage has no reset; pointer reset alone discards its contents.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            r_rd_valid  <= w_pop_ok;
            r_overflow  <= push & ~w_push_ok;
            r_underflow <= pop & ~w_pop_ok;
            if (w_pop_ok) r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

`ifdef SYNC_FIFO_ALMOST_EN
    localparam logic [ADDR_W:0] AF_LVL = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL = AE_LEVEL[ADDR_W:0];

    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= AF_LVL);
            r_almost_empty <= (w_count_nxt <= AE_LVL);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
